// File: rtl/neuron_pkg.sv
// Shared constants, FSM state type and the operand bus packing helper for
// the Neurone front-end sequencer.
package neuron_pkg;
   localparam int N_IN   = 9;
   localparam int DATA_W = 33;
   localparam int OUT_W  = 34;
   localparam int CNT_W  = 4;
   localparam int BUS_W  = N_IN * DATA_W;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      FIRE    = 2'd1,
      WAIT    = 2'd2,
      HOLD    = 2'd3
   } state_t;

   typedef logic [DATA_W-1:0] operand_t;
   typedef logic [BUS_W-1:0]  bus_t;

   // Lane k lands at bits [k*DATA_W +: DATA_W], matching Neurone input_k/weight_k.
   function automatic bus_t pack_bus(input operand_t lanes [N_IN]);
      bus_t r;
      r = '0;
      for (int k = 0; k < N_IN; k++) begin
         r[k*DATA_W +: DATA_W] = lanes[k];
      end
      return r;
   endfunction
endpackage

// File: rtl/neuron_feeder_if.sv
// Sample stream, weight write port, Neurone link and result port of the feeder.
interface neuron_feeder_if;
   import neuron_pkg::*;

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              w_wr_en;
   logic [3:0]        w_wr_addr;
   logic [DATA_W-1:0] w_wr_data;
   logic [BUS_W-1:0]  nrn_inputs;
   logic [BUS_W-1:0]  nrn_weights;
   logic              start_;
   logic              end_;
   logic [OUT_W-1:0]  nrn_out;
   logic              res_valid;
   logic [OUT_W-1:0]  res_data;
   logic              res_ready;
   logic              busy;
   logic              err;

   // The feeder is the slave; the host/layer controller and Neurone form the master side.
   modport slave (
      input  in_valid, in_data, w_wr_en, w_wr_addr, w_wr_data, end_, nrn_out, res_ready,
      output in_ready, nrn_inputs, nrn_weights, start_, res_valid, res_data, busy, err
   );

   modport master (
      output in_valid, in_data, w_wr_en, w_wr_addr, w_wr_data, end_, nrn_out, res_ready,
      input  in_ready, nrn_inputs, nrn_weights, start_, res_valid, res_data, busy, err
   );
endinterface

// File: rtl/neuron_operand_bank.sv
// Input and weight register files with one write port each, presented as
// flat operand buses for the Neurone.
module neuron_operand_bank
   import neuron_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_we,
   input  logic [CNT_W-1:0] in_addr,
   input  operand_t         in_wdata,
   input  logic             w_we,
   input  logic [3:0]       w_addr,
   input  operand_t         w_wdata,
   output bus_t             inputs_flat,
   output bus_t             weights_flat
);
   operand_t in_reg [N_IN];
   operand_t w_reg  [N_IN];

   generate
      for (genvar gi = 0; gi < N_IN; gi++) begin : g_lane
         always_ff @(posedge clk) begin
            if (rst) begin
               in_reg[gi] <= '0;
               w_reg[gi]  <= '0;
            end else begin
               if (in_we && (in_addr == CNT_W'(gi))) in_reg[gi] <= in_wdata;
               if (w_we && (w_addr == 4'(gi)))       w_reg[gi]  <= w_wdata;
            end
         end
      end
   endgenerate

   always_comb begin
      inputs_flat  = pack_bus(in_reg);
      weights_flat = pack_bus(w_reg);
   end
endmodule

// File: rtl/neuron_feeder.sv
// Collects N_IN samples, fires the Neurone with the stored weight bank,
// waits (bounded) for end_ and holds the result until it is consumed.
module neuron_feeder
   import neuron_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input logic           clk,
   input logic           rst,
   neuron_feeder_if.slave bus
);
   localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic [TMO_W-1:0]   tmo_reg, tmo_next;
   logic [OUT_W-1:0]   res_data_reg, res_data_next;
   logic               err_reg, err_next;
   logic               in_we;
   logic               w_we;
   logic               w_addr_ok;

   assign w_addr_ok = bus.w_wr_addr < 4'(N_IN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= COLLECT;
         count_reg    <= '0;
         tmo_reg      <= '0;
         res_data_reg <= '0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         tmo_reg      <= tmo_next;
         res_data_reg <= res_data_next;
         err_reg      <= err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      tmo_next      = tmo_reg;
      res_data_next = res_data_reg;
      err_next      = err_reg;
      in_we         = 1'b0;
      w_we          = 1'b0;
      bus.in_ready  = 1'b0;
      bus.start_    = 1'b0;
      bus.res_valid = 1'b0;
      bus.busy      = 1'b0;
      unique case (state_reg)
         COLLECT: begin
            bus.in_ready = 1'b1;
            w_we         = bus.w_wr_en && w_addr_ok;
            if (bus.in_valid) begin
               in_we = 1'b1;
               if (count_reg == CNT_W'(N_IN - 1)) begin
                  count_next = '0;
                  state_next = FIRE;
               end else begin
                  count_next = count_reg + CNT_W'(1);
               end
            end
         end
         FIRE: begin
            bus.start_ = 1'b1;
            bus.busy   = 1'b1;
            tmo_next   = '0;
            state_next = WAIT;
            if (bus.w_wr_en) err_next = 1'b1;
         end
         WAIT: begin
            bus.busy = 1'b1;
            if (bus.w_wr_en) err_next = 1'b1;
            if (bus.end_) begin
               res_data_next = bus.nrn_out;
               tmo_next      = '0;
               state_next    = HOLD;
            end else if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
               // A stalled Neurone still yields a (zero) result so the pipeline drains.
               err_next      = 1'b1;
               res_data_next = '0;
               tmo_next      = '0;
               state_next    = HOLD;
            end else begin
               tmo_next = tmo_reg + TMO_W'(1);
            end
         end
         HOLD: begin
            bus.res_valid = 1'b1;
            w_we          = bus.w_wr_en && w_addr_ok;
            if (bus.res_ready) state_next = COLLECT;
         end
         default: state_next = COLLECT;
      endcase
   end

   assign bus.res_data = res_data_reg;
   assign bus.err      = err_reg;

   neuron_operand_bank u_bank (
      .clk          (clk),
      .rst          (rst),
      .in_we        (in_we),
      .in_addr      (count_reg),
      .in_wdata     (bus.in_data),
      .w_we         (w_we),
      .w_addr       (bus.w_wr_addr),
      .w_wdata      (bus.w_wr_data),
      .inputs_flat  (bus.nrn_inputs),
      .weights_flat (bus.nrn_weights)
   );
endmodule

// File: tb/tb_neuron_feeder.sv
// Bench for neuron_feeder: Neurone stub, weight-write vector table and a
// result scoreboard driven from multi-cycle run sequences.
module tb_neuron_feeder;
   import neuron_pkg::*;

   localparam int TMO = 1024;

   typedef struct {
      logic [3:0]  addr;
      logic [32:0] data;
      int          lane;
      logic [32:0] exp;
   } wvec_t;

   typedef struct {
      logic [33:0] res;
      logic        err;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   neuron_feeder_if bus();

   neuron_feeder #(.TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   exp_t        sb[$];
   logic [32:0] wref [N_IN];
   logic [32:0] xin  [N_IN];
   wvec_t       wtab [11];

   // Neurone stub state
   logic        stub_end    = 1'b0;
   logic        force_end   = 1'b0;
   logic        stub_enable = 1'b1;
   logic        stub_fixed  = 1'b0;
   logic [33:0] stub_val    = '0;
   int          stub_delay  = 5;
   int          stub_cnt    = 0;
   int          start_count = 0;
   int          start_cyc   = 0;
   int          end_count   = 0;

   assign bus.end_ = stub_end | force_end;

   task automatic check(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [33:0] dot();
      longint s;
      s = 0;
      for (int k = 0; k < N_IN; k++) begin
         s += longint'($signed(bus.nrn_inputs[k*DATA_W +: DATA_W])) *
              longint'($signed(bus.nrn_weights[k*DATA_W +: DATA_W]));
      end
      return s[33:0];
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      stub_end = 1'b0;
      if (stub_cnt > 0) begin
         stub_cnt--;
         if (stub_cnt == 0) begin
            stub_end    = 1'b1;
            bus.nrn_out = stub_fixed ? stub_val : dot();
            end_count++;
         end
      end
      if (bus.start_) begin
         start_count++;
         start_cyc = cyc;
         if (stub_enable) stub_cnt = stub_delay;
      end
   end

   task automatic wr_weight(input logic [3:0] a, input logic [32:0] d);
      bus.w_wr_en   = 1'b1;
      bus.w_wr_addr = a;
      bus.w_wr_data = d;
      @(negedge clk);
      bus.w_wr_en   = 1'b0;
   endtask

   task automatic stream(input bit final_wr);
      for (int i = 0; i < N_IN; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = xin[i];
         if (final_wr && i == N_IN - 1) begin
            bus.w_wr_en   = 1'b1;
            bus.w_wr_addr = 4'(N_IN - 1);
            bus.w_wr_data = wref[N_IN - 1];
         end
         check("in_ready_collect", bus.in_ready, 1);
         @(negedge clk);
         bus.w_wr_en = 1'b0;
         if (i < N_IN - 1) check("no_early_start", bus.start_, 0);
      end
      bus.in_valid = 1'b0;
      check("start_after_9th", bus.start_, 1);
      check("busy_fire", bus.busy, 1);
      check("in_ready_fire", bus.in_ready, 0);
      @(negedge clk);
      check("start_one_cycle", bus.start_, 0);
   endtask

   task automatic wait_result(input int hold);
      int   n;
      int   rdy_seen;
      exp_t e;
      n = 0;
      rdy_seen = 0;
      while (!bus.res_valid && n < TMO + 200) begin
         if (bus.in_ready) rdy_seen++;
         @(negedge clk);
         n++;
      end
      check("in_ready_low_busy", 32'(rdy_seen), 0);
      e = sb.pop_front();
      if (!bus.res_valid) begin
         check("res_valid_wait", bus.res_valid, 1);
         return;
      end
      $display("result: data=%0d err=%0d lat=%0d", $signed(bus.res_data), bus.err, cyc - start_cyc);
      check("res_data", bus.res_data, e.res);
      check("err_at_result", bus.err, e.err);
      check("result_latency", 32'(cyc - start_cyc), 32'(e.lat));
      for (int h = 0; h < hold; h++) begin
         check("hold_valid", bus.res_valid, 1);
         check("hold_data", bus.res_data, e.res);
         check("hold_in_ready", bus.in_ready, 0);
         @(negedge clk);
      end
      bus.res_ready = 1'b1;
      check("valid_before_ready", bus.res_valid, 1);
      @(negedge clk);
      bus.res_ready = 1'b0;
      check("valid_drop", bus.res_valid, 0);
      check("in_ready_back", bus.in_ready, 1);
   endtask

   task automatic run(input logic [33:0] er, input logic ee, input int lat, input int hold,
                      input bit final_wr, input bit illegal);
      int sc0;
      exp_t e;
      sc0 = start_count;
      e.res = er;
      e.err = ee;
      e.lat = lat;
      sb.push_back(e);
      stream(final_wr);
      if (illegal) begin
         bus.w_wr_en   = 1'b1;
         bus.w_wr_addr = 4'd3;
         bus.w_wr_data = '1;
         @(negedge clk);
         bus.w_wr_en   = 1'b0;
         check("err_illegal_wr", bus.err, 1);
         check("w3_unchanged", bus.nrn_weights[3*DATA_W +: DATA_W], wref[3]);
      end
      wait_result(hold);
      check("one_start", 32'(start_count - sc0), 1);
   endtask

   initial begin
      int ec0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.w_wr_en   = 1'b0;
      bus.w_wr_addr = '0;
      bus.w_wr_data = '0;
      bus.nrn_out   = '0;
      bus.res_ready = 1'b0;

      wref[0] = 14264025;  wref[1] = 20602356;  wref[2] = 62294483;
      wref[3] = -5274598;  wref[4] = 61604893;  wref[5] = -5720134;
      wref[6] = 27585557;  wref[7] = -11946924; wref[8] = 17072096;
      for (int i = 0; i < N_IN; i++) begin
         wtab[i] = '{4'(i), wref[i], i, wref[i]};
         xin[i]  = 33'(i + 1);
      end
      wtab[9]  = '{4'd9,  33'd777, 8, wref[8]};
      wtab[10] = '{4'd15, '1,      0, wref[0]};

      // reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_start", bus.start_, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_data", bus.res_data, 0);
      check("rst_err", bus.err, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_weights", bus.nrn_weights, 0);
      check("rst_inputs", bus.nrn_inputs, 0);
      rst = 1'b0;
      @(negedge clk);

      // weight table, including out-of-range addresses that must be dropped
      for (int i = 0; i < 11; i++) begin
         wr_weight(wtab[i].addr, wtab[i].data);
         check("wtab_lane", bus.nrn_weights[wtab[i].lane*DATA_W +: DATA_W], wtab[i].exp);
      end
      check("err_after_table", bus.err, 0);

      run(34'd746129826, 1'b0, 6, 2, 1'b0, 1'b0);
      run(34'd746129826, 1'b0, 6, 20, 1'b0, 1'b0);
      run(34'd746129826, 1'b1, 6, 1, 1'b0, 1'b1);
      run(34'd746129826, 1'b1, 6, 1, 1'b0, 1'b0);

      // reset during WAIT, stub end_ lands two cycles after reset releases
      ec0 = end_count;
      stream(1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_start", bus.start_, 0);
      check("mid_rst_weights", bus.nrn_weights, 0);
      check("mid_rst_inputs", bus.nrn_inputs, 0);
      check("mid_rst_err", bus.err, 0);
      for (int i = 0; i < 4; i++) begin
         check("mid_rst_valid", bus.res_valid, 0);
         check("mid_rst_in_ready", bus.in_ready, 1);
         @(negedge clk);
      end
      check("late_end_seen", 32'(end_count - ec0), 1);

      // reload; last weight written on the final sample accept
      for (int i = 0; i < N_IN - 1; i++) wr_weight(4'(i), wref[i]);
      run(34'd746129826, 1'b0, 6, 1, 1'b1, 1'b0);

      stub_enable = 1'b0;
      run(34'd0, 1'b1, TMO + 1, 2, 1'b0, 1'b0);
      stub_enable = 1'b1;

      // spurious end_ while collecting
      force_end = 1'b1;
      @(negedge clk);
      force_end = 1'b0;
      check("spur_valid", bus.res_valid, 0);
      check("spur_in_ready", bus.in_ready, 1);
      check("spur_busy", bus.busy, 0);
      check("spur_res_data", bus.res_data, 0);

      for (int i = 0; i < N_IN; i++) xin[i] = '1;
      stub_fixed = 1'b1;
      stub_val   = -181470254;
      run(-34'sd181470254, 1'b1, 6, 1, 1'b0, 1'b0);
      check("sb_empty", 32'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
